dummy_adc_framer: RTL and testbench

Parametrised ADC emulator that generates multi-channel, multi-byte sample frames at a programmable rate and streams them bytewise into the slot FIFO. It sits where a real ADC converter module would: it drives the FIFO write port and watches the FIFO pointers for space. It adds selectable test patterns, frame-level flow control, an overflow flag and a frame counter. It is used for cosim and bring-up of the capture path without real ADC hardware.

---
 rtl/dummy_adc_framer.sv | 135 +++++++++++++
 tb/tb_dummy_adc_framer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/dummy_adc_framer.sv
// ADC emulator: emits one multi-channel sample frame per sample tick as a byte
// stream into the slot FIFO, with test patterns, overflow flag and frame counter.
module dummy_adc_framer #(
    parameter int          CLK_DIV         = 256,
    parameter int          NUM_CHANNELS    = 2,
    parameter int          SAMPLE_BYTES    = 3,
    parameter int          FIFO_ADDR_WIDTH = 11,
    parameter logic [31:0] PATTERN         = 32'hDEADBEEF
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       fifo_clk,
    output logic [7:0]                 fifo_data,
    output logic                       fifo_write,
    input  logic [FIFO_ADDR_WIDTH-1:0] fifo_addr_in,
    input  logic [FIFO_ADDR_WIDTH-1:0] fifo_addr_out,
    input  logic                       direction,
    input  logic                       enable,
    input  logic [1:0]                 mode,
    output logic                       overflow,
    output logic [15:0]                frame_count
);

    localparam int SAMPLE_BITS = 8 * SAMPLE_BYTES;
    localparam int NB          = NUM_CHANNELS * SAMPLE_BYTES;
    localparam int FRAME_BITS  = 8 * NB;
    localparam int CNT_W       = $clog2(CLK_DIV);
    localparam int IDX_W       = $clog2(NB + 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t                       r_state;
    logic [CNT_W-1:0]             r_tick_cnt;
    logic [FRAME_BITS-1:0]        r_frame;
    logic [IDX_W-1:0]             r_left;

    logic                         w_tick;
    logic                         w_half;
    logic                         w_request;
    logic [FIFO_ADDR_WIDTH-1:0]   w_used;
    logic [FIFO_ADDR_WIDTH-1:0]   w_free;
    logic                         w_space_ok;
    logic [SAMPLE_BITS-1:0]       w_sample;
    logic [FRAME_BITS-1:0]        w_frame;

    assign w_tick    = (r_tick_cnt == CNT_W'(CLK_DIV - 1));
    assign w_half    = (r_tick_cnt == CNT_W'(CLK_DIV / 2 - 1));
    assign w_request = w_tick && direction && enable;

    // Pointer difference wraps naturally at the pointer width.
    assign w_used     = fifo_addr_in - fifo_addr_out;
    assign w_free     = {FIFO_ADDR_WIDTH{1'b1}} - w_used;
    assign w_space_ok = (32'(w_free) >= 32'(NB));

    // Assemble the whole frame from the current mode and frame count; it is
    // captured into r_frame at the accepting tick, which latches both.
    always_comb begin
        w_frame  = '0;
        w_sample = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            case (mode)
                2'd0: w_sample = PATTERN[SAMPLE_BITS-1:0];
                2'd1: w_sample = SAMPLE_BITS'(frame_count) + SAMPLE_BITS'(c);
                2'd2: begin
                    w_sample = SAMPLE_BITS'(frame_count);
                    w_sample[SAMPLE_BITS-1 -: 8] = 8'(c);
                end
                default: w_sample = '0;
            endcase
            w_frame[c*SAMPLE_BITS +: SAMPLE_BITS] = w_sample;
        end
    end

    // Tick divider, FIFO clock, frame sequencer and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_tick_cnt  <= '0;
            r_frame     <= '0;
            r_left      <= '0;
            fifo_clk    <= 1'b0;
            fifo_data   <= 8'h00;
            fifo_write  <= 1'b0;
            overflow    <= 1'b0;
            frame_count <= 16'h0000;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + CNT_W'(1);
            if (w_tick || w_half) begin
                fifo_clk <= ~fifo_clk;
            end
            case (r_state)
                ST_IDLE: begin
                    fifo_write <= 1'b0;
                    fifo_data  <= 8'h00;
                    if (w_request) begin
                        if (w_space_ok) begin
                            r_state    <= ST_SEND;
                            r_frame    <= w_frame >> 8;
                            r_left     <= IDX_W'(NB - 1);
                            fifo_write <= 1'b1;
                            fifo_data  <= w_frame[7:0];
                        end else begin
                            overflow <= 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    // A frame in flight always completes; a tick now is a drop.
                    if (w_request) begin
                        overflow <= 1'b1;
                    end
                    if (r_left != '0) begin
                        fifo_data <= r_frame[7:0];
                        r_frame   <= r_frame >> 8;
                        r_left    <= r_left - IDX_W'(1);
                    end else begin
                        r_state     <= ST_IDLE;
                        fifo_write  <= 1'b0;
                        fifo_data   <= 8'h00;
                        frame_count <= frame_count + 16'd1;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    fifo_write <= 1'b0;
                    fifo_data  <= 8'h00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dummy_adc_framer.sv
// Scoreboard bench for dummy_adc_framer with default parameters: a reference
// model pushes expected bytes at each accepted tick; a monitor pops and compares.
module tb_dummy_adc_framer;

    logic        clk = 1'b0;
    logic        reset;
    logic        fifo_clk;
    logic [7:0]  fifo_data;
    logic        fifo_write;
    logic [10:0] fifo_addr_in;
    logic [10:0] fifo_addr_out;
    logic        direction;
    logic        enable;
    logic [1:0]  mode;
    logic        overflow;
    logic [15:0] frame_count;

    dummy_adc_framer dut (
        .clk           (clk),
        .reset         (reset),
        .fifo_clk      (fifo_clk),
        .fifo_data     (fifo_data),
        .fifo_write    (fifo_write),
        .fifo_addr_in  (fifo_addr_in),
        .fifo_addr_out (fifo_addr_out),
        .direction     (direction),
        .enable        (enable),
        .mode          (mode),
        .overflow      (overflow),
        .frame_count   (frame_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [7:0]  sb[$];
    int          m_cnt  = 0;
    int          m_left = 0;
    logic [15:0] m_fc   = 16'h0000;
    logic        m_ovf  = 1'b0;
    logic        m_fclk = 1'b0;
    logic        mon_en = 1'b0;

    function automatic int free_space(input logic [10:0] ain, input logic [10:0] aout);
        logic [10:0] used;
        used = ain - aout;
        return 2047 - int'(used);
    endfunction

    task automatic push_frame(input logic [1:0] md, input logic [15:0] n);
        logic [23:0] s;
        logic [7:0]  cb;
        for (int c = 0; c < 2; c++) begin
            cb = 8'(c);
            case (md)
                2'd0:    s = 24'hADBEEF;
                2'd1:    s = 24'(n) + 24'(c);
                2'd2:    s = {cb, n};
                default: s = 24'h000000;
            endcase
            for (int b = 0; b < 3; b++) sb.push_back(s[8*b +: 8]);
        end
    endtask

    // Model: sampled on the same edge as the DUT.
    always @(posedge clk) begin
        if (reset) begin
            m_cnt  <= 0;
            m_left <= 0;
            m_fc   <= 16'h0000;
            m_ovf  <= 1'b0;
            m_fclk <= 1'b0;
            sb.delete();
        end else begin
            m_cnt <= (m_cnt == 255) ? 0 : m_cnt + 1;
            if (m_cnt == 127 || m_cnt == 255) m_fclk <= ~m_fclk;
            if (m_left != 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) m_fc <= m_fc + 16'd1;
            end
            if (m_cnt == 255 && direction && enable) begin
                if (m_left == 0 && free_space(fifo_addr_in, fifo_addr_out) >= 6) begin
                    push_frame(mode, m_fc);
                    m_left <= 6;
                end else begin
                    m_ovf <= 1'b1;
                end
            end
        end
    end

    // Monitor on the inactive edge.
    always @(negedge clk) begin
        if (mon_en) begin
            check_value("write", 32'(fifo_write), 32'(m_left != 0));
            if (fifo_write && sb.size() > 0) begin
                check_value("byte", 32'(fifo_data), 32'(sb.pop_front()));
            end else if (!fifo_write) begin
                check_value("idle_data", 32'(fifo_data), 32'h0);
            end
            check_value("overflow", 32'(overflow), 32'(m_ovf));
            check_value("frame_count", 32'(frame_count), 32'(m_fc));
            check_value("fifo_clk", 32'(fifo_clk), 32'(m_fclk));
        end
    end

    task automatic wait_write();
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            if (fifo_write) break;
        end
        check_value("wait_write", 32'(fifo_write), 32'h1);
    endtask

    task automatic wait_fc_change();
        logic [15:0] start;
        start = frame_count;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            if (frame_count != start) break;
        end
        check_value("wait_frame", 32'(frame_count), 32'(start + 16'd1));
    endtask

    logic [7:0]  t1_bytes [6] = '{8'hEF, 8'hBE, 8'hAD, 8'hEF, 8'hBE, 8'hAD};
    logic [15:0] fc0;
    int          lat;

    initial begin
        reset = 1'b1; direction = 1'b1; enable = 1'b1; mode = 2'd0;
        fifo_addr_in = 11'h000; fifo_addr_out = 11'h000;
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b1;
        check_value("rst_write", 32'(fifo_write), 32'h0);
        check_value("rst_data", 32'(fifo_data), 32'h0);
        check_value("rst_fc", 32'(frame_count), 32'h0);
        check_value("rst_fclk", 32'(fifo_clk), 32'h0);
        reset = 1'b0;

        // Basic frame: fifo_clk edge and first-frame latency
        repeat (127) @(posedge clk);
        #1 check_value("fclk_lo", 32'(fifo_clk), 32'h0);
        @(posedge clk);
        #1 check_value("fclk_hi", 32'(fifo_clk), 32'h1);
        repeat (127) @(posedge clk);
        #1 check_value("pre_tick", 32'(fifo_write), 32'h0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check_value("t1_wr", 32'(fifo_write), 32'h1);
            check_value("t1_byte", 32'(fifo_data), 32'(t1_bytes[i]));
        end
        @(posedge clk); #1;
        check_value("t1_end", 32'(fifo_write), 32'h0);
        check_value("t1_fc", 32'(frame_count), 32'h1);

        // Ramp and channel-ID modes, then zeros
        mode = 2'd1;
        repeat (3 * 256) @(posedge clk);
        #1 mode = 2'd2;
        repeat (2 * 256) @(posedge clk);
        #1 mode = 2'd3;
        repeat (256) @(posedge clk);
        #1 mode = 2'd1;

        // Pointer wrap-around, then free space exactly one frame
        fifo_addr_in = 11'h002; fifo_addr_out = 11'h7F0;
        wait_fc_change();
        check_value("wrap_ovf", 32'(overflow), 32'h0);
        fifo_addr_in = 11'h7F9; fifo_addr_out = 11'h000;
        wait_fc_change();
        check_value("free6_ovf", 32'(overflow), 32'h0);

        // Direction low: idle; then enable dropped mid-frame
        fifo_addr_in = 11'h000;
        direction = 1'b0;
        fc0 = frame_count;
        repeat (3 * 256) @(posedge clk);
        #1 check_value("dir0_fc", 32'(frame_count), 32'(fc0));
        check_value("dir0_ovf", 32'(overflow), 32'h0);
        direction = 1'b1;
        wait_write();
        @(posedge clk); #1;
        enable = 1'b0;
        repeat (2 * 256) @(posedge clk);
        #1 check_value("en0_fc", 32'(frame_count), 32'(fc0 + 16'd1));
        enable = 1'b1;

        // Insufficient space drops the frame; overflow is sticky
        fifo_addr_in = 11'h7FB; fifo_addr_out = 11'h000;
        fc0 = frame_count;
        repeat (256) @(posedge clk);
        #1 check_value("drop_ovf", 32'(overflow), 32'h1);
        check_value("drop_fc", 32'(frame_count), 32'(fc0));
        fifo_addr_out = 11'h7FB;
        wait_fc_change();
        check_value("sticky_ovf", 32'(overflow), 32'h1);

        // Reset in the middle of a frame
        mode = 2'd1;
        wait_write();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check_value("mid_rst_wr", 32'(fifo_write), 32'h0);
        check_value("mid_rst_ovf", 32'(overflow), 32'h0);
        check_value("mid_rst_fc", 32'(frame_count), 32'h0);
        reset = 1'b0;
        lat = 0;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            lat++;
            if (fifo_write) break;
        end
        check_value("rst_latency", 32'(lat), 32'd256);
        check_value("rst_byte0", 32'(fifo_data), 32'h00);
        wait_fc_change();
        check_value("sb_drained", 32'(sb.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
